secuenciador_dispensado: RTL and testbench
==========================================

Name: secuenciador_dispensado

Overview:
- Recipe sequencer for the coffee machine: after payment is accepted, it drives the ingredient valves (agua, cafe, leche, choco, azucar) in a fixed order.
- Each valve is held for a per-drink duration in seconds, with seconds derived from a clock prescaler.
- Sits between the payment/selection FSM, which supplies start/bebida/azucar_lvl, and the valve outputs. It replaces ad-hoc per-ingredient timing with one shared timer.

Parameters:
- TICK_DIV, 50000000, clock cycles per second (bench uses 4).
- AZUCAR_MAX, 3, max sugar seconds; azucar_lvl is clamped to this value.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-low
- start  input  1  request a drink; sampled only in IDLE
- bebida  input  2  drink select: 0 expreso, 1 cafe con leche, 2 capuccino, 3 chocolate
- azucar_lvl  input  2  sugar seconds 0..3
- abort  input  1  cancel the drink in progress
- busy  output  1  high while a drink is being dispensed
- done  output  1  one-cycle pulse on normal completion
- agua, cafe, leche, choco, azucar  output  1 each  valve enables, at most one high
- paso  output  3  current step: 0 idle, 1 agua, 2 cafe, 3 leche, 4 choco, 5 azucar
- seg_restantes  output  4  whole seconds remaining in the current step; 0 when idle

Behaviour:
- Reset: rst sampled low at an edge gives, at that edge:
  - state IDLE, all valves 0, busy 0, done 0, paso 0, seg_restantes 0;
  - prescaler and second counter cleared.
  - Reset takes priority over everything and is honoured mid-drink; no done is produced.
- All outputs are registered.
- Recipe table, durations in seconds, step order agua, cafe, leche, choco, azucar:
  - expreso: 2, 3, 0, 0, S
  - cafe con leche: 2, 2, 3, 0, S
  - capuccino: 1, 2, 4, 0, S
  - chocolate: 2, 0, 2, 3, S
  - S = min(azucar_lvl, AZUCAR_MAX).
- Zero-duration steps are skipped with no idle cycle: a priority search finds the next step with nonzero duration.
- States: IDLE, RUN, FIN.
- IDLE:
  - On start=1 at edge k: latch bebida and azucar_lvl, then enter RUN.
  - At edge k: busy=1, first nonzero step's valve=1, paso set, seg_restantes = that step's duration.
  - Inputs changing after edge k have no effect.
- RUN:
  - Prescaler counts 0..TICK_DIV-1; seg_restantes decrements when the prescaler wraps.
  - Each valve is high for exactly duration*TICK_DIV cycles.
  - At the wrap that would take seg_restantes to 0 with another nonzero step remaining: switch to the next step's valve on the same edge. The new step's seg_restantes is loaded and the prescaler restarts at 0.
  - If no nonzero step remains: go to FIN.
- FIN (transition edge):
  - All valves 0, busy 0, paso 0, seg_restantes 0, done=1 for exactly one cycle.
  - The FSM is back in IDLE on the following cycle.
  - A start present during the done cycle is accepted at the next edge.
- start while busy: ignored, not queued.
- abort=1 in RUN:
  - Next edge: IDLE, valves 0, busy 0, paso 0, no done.
  - abort in IDLE has no effect.
  - abort and start together in IDLE: start wins.
- Invariant: at most one valve high. busy=1 exactly when paso≠0.
- Total busy cycles = (sum of durations)*TICK_DIV.

Optional Feature:
- Macro: SECUENCIADOR_PAUSA_EN.
- When defined:
  - Adds input pausa (1 bit). While pausa=1 in RUN, all valves read 0 and the prescaler and seg_restantes hold; busy stays 1 and paso holds.
  - On pausa=0, the same valve re-asserts on the next edge and the remaining time continues exactly.
  - abort and rst still act during pause.
- When undefined: no pausa port and no hold logic.

Test Plan:
- TICK_DIV=4, expreso, azucar_lvl=0, start pulse at edge 0 -> agua high cycles 0-7, cafe 8-19, done=1 at cycle 20 only, busy 0-19, leche/choco/azucar never high.
- chocolate, azucar_lvl=2 -> agua 8 cycles, choco skipped straight after? No: order agua 8, leche 8, choco 12, azucar 8; cafe never asserted; done at cycle 36; seg_restantes sequence 2,1,2,1,3,2,1,2,1.
- Capuccino started; at cycle 5 assert start with bebida=3 -> ignored; run completes as capuccino (28 cycles), done once.
- Cafe con leche; abort at cycle 10 (cafe step) -> cycle 11 all valves 0, busy 0, no done; new start at cycle 13 runs a full 28-cycle recipe.
- Capuccino; rst=0 at cycle 12 -> next edge all outputs 0, no done; after rst=1 the block idles until start.
- With SECUENCIADOR_PAUSA_EN, expreso: pausa high cycles 3-9 -> agua low during pause; agua total high 8 cycles, done delayed by exactly 7 cycles to cycle 27.

Source files
------------

// File: rtl/secuenciador_dispensado.sv
// Recipe sequencer for the coffee machine: opens agua, cafe, leche, choco, azucar in order,
// each for a per-drink number of seconds. Define SECUENCIADOR_PAUSA_EN to add the pausa input.
module secuenciador_dispensado #(
  parameter int TICK_DIV   = 50000000,
  parameter int AZUCAR_MAX = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] bebida,
  input  logic [1:0] azucar_lvl,
  input  logic       abort,
`ifdef SECUENCIADOR_PAUSA_EN
  input  logic       pausa,
`endif
  output logic       busy,
  output logic       done,
  output logic       agua,
  output logic       cafe,
  output logic       leche,
  output logic       choco,
  output logic       azucar,
  output logic [2:0] paso,
  output logic [3:0] seg_restantes
);

  localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [1:0]    AZU_TOPE  = (AZUCAR_MAX >= 3) ? 2'd3 : 2'(AZUCAR_MAX);

  typedef enum logic [1:0] {IDLE, RUN, FIN} estado_t;

  estado_t       estado;
  logic [1:0]    beb_q;
  logic [1:0]    azu_q;
  logic [PW-1:0] presc;
  logic [4:0]    valv;
  logic [1:0]    azu_in;
  logic [2:0]    paso_ini;
  logic [2:0]    paso_sig;

  // Seconds for step p (1 agua .. 5 azucar) of drink beb with sugar level azu.
  function automatic logic [3:0] duracion(input logic [1:0] beb, input logic [1:0] azu,
                                          input logic [2:0] p);
    logic [3:0] d;
    d = 4'd0;
    case (p)
      3'd1: d = (beb == 2'd2) ? 4'd1 : 4'd2;
      3'd2: case (beb)
              2'd0:    d = 4'd3;
              2'd3:    d = 4'd0;
              default: d = 4'd2;
            endcase
      3'd3: case (beb)
              2'd0:    d = 4'd0;
              2'd1:    d = 4'd3;
              2'd2:    d = 4'd4;
              default: d = 4'd2;
            endcase
      3'd4: d = (beb == 2'd3) ? 4'd3 : 4'd0;
      3'd5: d = {2'b00, azu};
      default: d = 4'd0;
    endcase
    return d;
  endfunction

  // First step after 'actual' with a nonzero duration; 0 when the recipe is exhausted.
  function automatic logic [2:0] siguiente(input logic [1:0] beb, input logic [1:0] azu,
                                           input logic [2:0] actual);
    logic [2:0] s;
    s = 3'd0;
    for (int j = 5; j >= 1; j--)
      if (3'(j) > actual && duracion(beb, azu, 3'(j)) != 4'd0) s = 3'(j);
    return s;
  endfunction

  function automatic logic [4:0] valvula(input logic [2:0] p);
    return (p == 3'd0 || p > 3'd5) ? 5'd0 : (5'b00001 << (p - 3'd1));
  endfunction

  assign azu_in   = (azucar_lvl > AZU_TOPE) ? AZU_TOPE : azucar_lvl;
  assign paso_ini = siguiente(bebida, azu_in, 3'd0);
  assign paso_sig = siguiente(beb_q, azu_q, paso);
  assign {azucar, choco, leche, cafe, agua} = valv;

  always_ff @(posedge clk) begin
    // NOTE: every register here is written with <= so all of them update together from
    // the values sampled at this edge, independent of statement order.
    if (!rst) begin
      estado        <= IDLE;
      beb_q         <= '0;
      azu_q         <= '0;
      presc         <= '0;
      valv          <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      paso          <= '0;
      seg_restantes <= '0;
    end else begin
      done <= 1'b0;
      unique case (estado)
        IDLE, FIN: begin
          // The done cycle accepts a new start just like IDLE.
          if (start) begin
            estado        <= RUN;
            beb_q         <= bebida;
            azu_q         <= azu_in;
            presc         <= '0;
            busy          <= 1'b1;
            paso          <= paso_ini;
            seg_restantes <= duracion(bebida, azu_in, paso_ini);
            valv          <= valvula(paso_ini);
          end else begin
            estado <= IDLE;
          end
        end
        RUN: begin
          if (abort) begin
            estado        <= IDLE;
            presc         <= '0;
            valv          <= '0;
            busy          <= 1'b0;
            paso          <= '0;
            seg_restantes <= '0;
          end
`ifdef SECUENCIADOR_PAUSA_EN
          else if (pausa) begin
            valv <= '0;
          end
`endif
          else begin
            valv <= valvula(paso);
            if (presc == PRESC_MAX) begin
              presc <= '0;
              if (seg_restantes != 4'd1) begin
                seg_restantes <= seg_restantes - 4'd1;
              end else if (paso_sig != 3'd0) begin
                paso          <= paso_sig;
                seg_restantes <= duracion(beb_q, azu_q, paso_sig);
                valv          <= valvula(paso_sig);
              end else begin
                estado        <= FIN;
                done          <= 1'b1;
                valv          <= '0;
                busy          <= 1'b0;
                paso          <= '0;
                seg_restantes <= '0;
              end
            end else begin
              presc <= presc + 1'b1;
            end
          end
        end
        default: estado <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_secuenciador_dispensado.sv
// Bench for secuenciador_dispensado: table of per-recipe valve budgets, hand-written corner
// sequences and randomized drinks against a cycle-list reference model.
module tb_secuenciador_dispensado;

  localparam int TICK    = 4;
  localparam int AZU_MAX = 2;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [4:0] valv;
    logic [2:0] paso;
    logic [3:0] seg;
  } out_t;

  typedef struct {
    logic [1:0] beb;
    logic [1:0] azu;
    int         agua_c;
    int         cafe_c;
    int         leche_c;
    int         choco_c;
    int         azu_c;
    int         total;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic [1:0] bebida, azucar_lvl;
  logic       busy, done, agua, cafe, leche, choco, azucar;
  logic [2:0] paso;
  logic [3:0] seg_restantes;
`ifdef SECUENCIADOR_PAUSA_EN
  logic       pausa = 1'b0;
`endif

  int   n_tests = 0;
  int   n_fail  = 0;
  out_t act;
  out_t exp_q[$];
  vec_t tabla[6];

  // Seconds per step agua, cafe, leche, choco for each drink.
  int receta [4][4] = '{'{2, 3, 0, 0}, '{2, 2, 3, 0}, '{1, 2, 4, 0}, '{2, 0, 2, 3}};

  secuenciador_dispensado #(.TICK_DIV(TICK), .AZUCAR_MAX(AZU_MAX)) dut (
    .clk(clk), .rst(rst), .start(start), .bebida(bebida), .azucar_lvl(azucar_lvl),
    .abort(abort),
`ifdef SECUENCIADOR_PAUSA_EN
    .pausa(pausa),
`endif
    .busy(busy), .done(done), .agua(agua), .cafe(cafe), .leche(leche), .choco(choco),
    .azucar(azucar), .paso(paso), .seg_restantes(seg_restantes)
  );

  always #5 clk = ~clk;

  assign act = {busy, done, azucar, choco, leche, cafe, agua, paso, seg_restantes};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Expected outputs cycle by cycle after the start edge, ending with the done cycle.
  function automatic void modelo(input int beb, input int azu);
    int   d;
    out_t r;
    exp_q.delete();
    for (int s = 0; s < 5; s++) begin
      d = (s == 4) ? ((azu < AZU_MAX) ? azu : AZU_MAX) : receta[beb][s];
      for (int c = 0; c < d * TICK; c++) begin
        r.busy = 1'b1;
        r.done = 1'b0;
        r.valv = 5'(1 << s);
        r.paso = 3'(s + 1);
        r.seg  = 4'(d - c / TICK);
        exp_q.push_back(r);
      end
    end
    r = '0;
    r.done = 1'b1;
    exp_q.push_back(r);
  endfunction

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle", 32'(act), 32'(out_t'('0)));
      start      = 1'b0;
      abort      = 1'($urandom_range(0, 1));
      bebida     = 2'($urandom_range(0, 3));
      azucar_lvl = 2'($urandom_range(0, 3));
    end
  endtask

  // Starts a drink (exp_q must already hold its model) and compares every cycle.
  // cut_at >= 0 applies abort (or reset if cut_rst) after that cycle; junk_at re-asserts start.
  task automatic run_drink(input string tag, input logic [1:0] beb, input logic [1:0] azu,
                           input int cut_at, input bit cut_rst, input int junk_at);
    start      = 1'b1;
    bebida     = beb;
    azucar_lvl = azu;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      if (cut_at >= 0 && i == cut_at + 1) begin
        check($sformatf("%s after cut c%0d", tag, i), 32'(act), 32'(out_t'('0)));
        rst   = 1'b1;
        abort = 1'b0;
        return;
      end
      check($sformatf("%s c%0d", tag, i), 32'(act), 32'(exp_q[i]));
      start      = (i == junk_at);
      abort      = 1'b0;
      rst        = 1'b1;
      bebida     = 2'($urandom_range(0, 3));
      azucar_lvl = 2'($urandom_range(0, 3));
      if (i == cut_at) begin
        if (cut_rst) rst = 1'b0;
        else         abort = 1'b1;
      end
    end
  endtask

  task automatic table_test();
    for (int t = 0; t < 6; t++) begin
      int cnt [5];
      int fin_at;
      int bad;
      int busy_c;
      for (int s = 0; s < 5; s++) cnt[s] = 0;
      fin_at     = -1;
      bad        = 0;
      busy_c     = 0;
      start      = 1'b1;
      bebida     = tabla[t].beb;
      azucar_lvl = tabla[t].azu;
      for (int cyc = 0; cyc < 200 && fin_at < 0; cyc++) begin
        @(negedge clk);
        start = 1'b0;
        if (done) begin
          fin_at = cyc;
        end else begin
          if (busy) busy_c++;
          for (int s = 0; s < 5; s++) if (act.valv[s]) cnt[s]++;
          if ($countones(act.valv) > 1 || busy != (paso != 3'd0)) bad++;
        end
      end
      check($sformatf("tabla%0d done cycle", t), fin_at, tabla[t].total);
      check($sformatf("tabla%0d busy cycles", t), busy_c, tabla[t].total);
      check($sformatf("tabla%0d agua", t),   cnt[0], tabla[t].agua_c);
      check($sformatf("tabla%0d cafe", t),   cnt[1], tabla[t].cafe_c);
      check($sformatf("tabla%0d leche", t),  cnt[2], tabla[t].leche_c);
      check($sformatf("tabla%0d choco", t),  cnt[3], tabla[t].choco_c);
      check($sformatf("tabla%0d azucar", t), cnt[4], tabla[t].azu_c);
      check($sformatf("tabla%0d invariants", t), bad, 0);
    end
  endtask

`ifdef SECUENCIADOR_PAUSA_EN
  task automatic pause_test();
    int agua_c  = 0;
    int done_at = -1;
    int bad     = 0;
    start      = 1'b1;
    bebida     = 2'd0;
    azucar_lvl = 2'd0;
    for (int i = 0; i < 60 && done_at < 0; i++) begin
      @(negedge clk);
      start = 1'b0;
      pausa = (i >= 2 && i <= 8);
      if (agua) agua_c++;
      if (i >= 3 && i <= 9 && (agua || !busy || paso != 3'd1)) bad++;
      if (done) done_at = i;
    end
    pausa = 1'b0;
    check("pausa agua cycles", agua_c, 8);
    check("pausa hold", bad, 0);
    check("pausa done cycle", done_at, 27);
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tabla[0] = '{2'd0, 2'd0, 8, 12, 0, 0, 0, 20};
    tabla[1] = '{2'd1, 2'd1, 8, 8, 12, 0, 4, 32};
    tabla[2] = '{2'd2, 2'd3, 4, 8, 16, 0, 8, 36};   // sugar clamped to AZU_MAX
    tabla[3] = '{2'd3, 2'd2, 8, 0, 8, 12, 8, 36};
    tabla[4] = '{2'd0, 2'd3, 8, 12, 0, 0, 8, 28};
    tabla[5] = '{2'd3, 2'd0, 8, 0, 8, 12, 0, 28};

    rst = 1'b0; start = 1'b1; abort = 1'b0; bebida = 2'd0; azucar_lvl = 2'd0;
    repeat (2) @(negedge clk);
    check("reset state", 32'(act), 32'(out_t'('0)));
    rst = 1'b1; start = 1'b0;
    idle_cycles(3);

    table_test();
    idle_cycles(2);

    modelo(0, 0); run_drink("expreso", 2'd0, 2'd0, -1, 1'b0, -1);
    modelo(3, 2); run_drink("chocolate chained", 2'd3, 2'd2, -1, 1'b0, -1);
    idle_cycles(1);
    modelo(2, 0); run_drink("capuccino junk start", 2'd2, 2'd0, -1, 1'b0, 4);
    idle_cycles(1);
    modelo(1, 0); run_drink("leche abort", 2'd1, 2'd0, 9, 1'b0, -1);
    idle_cycles(1);
    modelo(1, 0); run_drink("leche restart", 2'd1, 2'd0, -1, 1'b0, -1);
    idle_cycles(1);
    modelo(2, 1); run_drink("capuccino reset", 2'd2, 2'd1, 11, 1'b1, -1);
    idle_cycles(4);

`ifdef SECUENCIADOR_PAUSA_EN
    pause_test();
    idle_cycles(2);
`endif

    for (int k = 0; k < 40; k++) begin
      int b;
      int a;
      int n;
      int cut;
      int junk;
      b = $urandom_range(0, 3);
      a = $urandom_range(0, 3);
      modelo(b, a);
      n    = exp_q.size() - 1;
      cut  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : -1;
      junk = ($urandom_range(0, 1) == 0) ? $urandom_range(0, n - 1) : -1;
      run_drink($sformatf("rnd%0d", k), 2'(b), 2'(a), cut, ($urandom_range(0, 3) == 0), junk);
      idle_cycles($urandom_range(0, 3));
    end
    idle_cycles(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
